oc_bus_arbiter: RTL and testbench



---
 rtl/oc_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_oc_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/oc_bus_arbiter.sv
// oc_bus_arbiter
// Round-robin arbiter that gives one of four local requesters ownership of a
// shared open-collector, wired-AND "bus busy" line. The line is claimed by
// pulling it low and is only sampled while idle, so that the arbiter defers to
// foreign masters already holding the wire. An owner keeps the grant until it
// signals done, drops its request, or reaches HOLD_MAX cycles.
module oc_bus_arbiter #(
    parameter int HOLD_MAX = 15,
    // Board-level driver delays in ns (min:typ:max). The claim itself is
    // edge-aligned; these figures describe the LS05-style pin that follows it.
    parameter int tPLH_min = 0,
    parameter int tPLH_typ = 17,
    parameter int tPLH_max = 32,
    parameter int tPHL_min = 0,
    parameter int tPHL_typ = 15,
    parameter int tPHL_max = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       bus_n,
    output wire        busy_n,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       tmo
);

    // The hold counter is 4 bits wide, so HOLD_MAX must fit in 1..15.
    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
        $error("oc_bus_arbiter: HOLD_MAX must be within 1..15");
    end

    // Delay triples must be ordered min <= typ <= max.
    if (tPLH_min > tPLH_typ || tPLH_typ > tPLH_max ||
        tPHL_min > tPHL_typ || tPHL_typ > tPHL_max) begin : g_bad_delays
        $error("oc_bus_arbiter: driver delay triples must be ordered min:typ:max");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_MAX  = 4'(HOLD_MAX);
    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] last;      // most recent owner; the scan starts just after it
    logic [3:0] cnt;       // cycles already spent in GRANT
    logic       claim;     // registered "we hold the shared line"

    logic [1:0] scan_base;
    logic [7:0] req_twice;
    logic [3:0] req_rot;
    logic [1:0] rot_idx;
    logic [1:0] pick;
    logic [3:0] pick_onehot;

    logic       owner_done;
    logic       owner_gone;
    logic       hold_expired;
    logic       release_now;
    logic       timeout_only;

    // Round-robin choice: rotate req so that last+1 sits at bit 0, take the
    // lowest set bit, then undo the rotation.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch can be inferred.
        scan_base   = last + 2'd1;
        req_twice   = {req, req};
        req_rot     = req_twice[scan_base +: 4];
        rot_idx     = 2'd0;
        if (req_rot[0]) begin
            rot_idx = 2'd0;
        end else if (req_rot[1]) begin
            rot_idx = 2'd1;
        end else if (req_rot[2]) begin
            rot_idx = 2'd2;
        end else if (req_rot[3]) begin
            rot_idx = 2'd3;
        end
        pick        = scan_base + rot_idx;
        pick_onehot = 4'b0001 << pick;
    end

    // Release causes while granted; tmo only flags a release caused by the
    // hold limit alone.
    always_comb begin
        owner_done   = done;
        owner_gone   = ~req[owner];
        hold_expired = (cnt == CNT_LAST);
        release_now  = owner_done | owner_gone | hold_expired;
        timeout_only = hold_expired & ~owner_done & ~owner_gone;
    end

    // Arbitration FSM with registered grant, owner, timeout pulse and claim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            owner <= 2'd0;
            last  <= 2'd3;
            cnt   <= 4'd0;
            tmo   <= 1'b0;
            claim <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    // bus_n low means a foreign master holds the wire.
                    if ((|req) && bus_n) begin
                        state <= ARB;
                        claim <= 1'b1;
                    end
                end
                ARB: begin
                    // The owner comes from req as seen at this edge.
                    if (req == 4'b0000) begin
                        state <= IDLE;
                        claim <= 1'b0;
                    end else begin
                        owner <= pick;
                        gnt   <= pick_onehot;
                        cnt   <= 4'd0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= 4'b0000;
                        last  <= owner;
                        tmo   <= timeout_only;
                        state <= RELEASE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    // Turnaround cycle done; let the line float again.
                    state <= IDLE;
                    claim <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    claim <= 1'b0;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

    // Open-collector drive: strong low while claiming, released (high-Z) otherwise.
    assign busy_n = claim ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_oc_bus_arbiter.sv
// tb_oc_bus_arbiter
// Self-checking bench for oc_bus_arbiter. Each bus tenure is described as an
// episode (requests, foreign hold time, how the owner finishes) and the bench
// derives the expected timeline from the arbitration rules: rotation order,
// grant length min(finish cycle, HOLD), timeout pulse and turnaround gaps.
module tb_oc_bus_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       foreign_hold;
    wire        bus_line;
    wire        bus_n;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    // Reference state: index of the most recent owner.
    logic [1:0] m_last;

    // Shared wired-AND net: external pull-up, our OC driver, and a foreign master.
    pullup (bus_line);
    assign bus_n = bus_line & ~foreign_hold;

    oc_bus_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .bus_n  (bus_n),
        .busy_n (bus_line),
        .gnt    (gnt),
        .owner  (owner),
        .tmo    (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requester after 'after' in circular order.
    function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] after);
        int idx;
        for (int i = 1; i <= 4; i++) begin
            idx = (int'(after) + i) % 4;
            if (r[idx]) return 2'(idx);
        end
        return after;
    endfunction

    // One tenure starting from IDLE.
    // r: req at the IDLE edge, r2: req at the ARB edge, f: cycles the foreign
    // master holds the line, ev: 0 none / 1 done / 2 owner drops req,
    // k: grant cycle on whose closing edge ev happens.
    task automatic episode(input logic [3:0] r, input logic [3:0] r2,
                           input int f, input int ev, input int k);
        logic [1:0] exp_owner;
        logic [3:0] exp_gnt;
        int         len;
        logic       exp_tmo;
        req  = r;
        done = 1'b0;
        if (f > 0) begin
            foreign_hold = 1'b1;
            repeat (f) begin
                step();
                check("defer_gnt", gnt, 4'b0000);
                check("defer_line", bus_line, 1'b1);
            end
            foreign_hold = 1'b0;
        end
        step();
        check("arb_gnt", gnt, 4'b0000);
        check("arb_claim", bus_line, 1'b0);
        req = r2;
        step();
        if (r2 == 4'b0000) begin
            check("wd_gnt", gnt, 4'b0000);
            check("wd_line", bus_line, 1'b1);
            return;
        end
        exp_owner = rr_next(r2, m_last);
        exp_gnt   = 4'b0001 << exp_owner;
        check("grant", gnt, exp_gnt);
        check("owner", owner, exp_owner);
        len     = (ev != 0 && k <= HOLD) ? k : HOLD;
        exp_tmo = !(ev != 0 && k <= HOLD);
        for (int c = 1; c <= len; c++) begin
            done = (ev == 1 && c == k);
            req  = (ev == 2 && c == k) ? (r2 & ~exp_gnt) : r2;
            step();
            if (c < len) begin
                check("hold_gnt", gnt, exp_gnt);
                check("hold_tmo", tmo, 1'b0);
                check("hold_line", bus_line, 1'b0);
            end else begin
                check("rel_gnt", gnt, 4'b0000);
                check("rel_tmo", tmo, exp_tmo);
                check("rel_line", bus_line, 1'b0);
                check("rel_owner", owner, exp_owner);
            end
        end
        done   = 1'b0;
        req    = r2;
        m_last = exp_owner;
        step();
        check("idle_tmo", tmo, 1'b0);
        check("idle_gnt", gnt, 4'b0000);
        check("idle_line", bus_line, 1'b1);
    endtask

    // Reset asserted between edges while a grant is active.
    task automatic mid_grant_reset();
        req  = 4'b1111;
        done = 1'b0;
        step();
        step();
        check("mg_grant", gnt, 4'b0001 << rr_next(4'b1111, m_last));
        #3;
        rst = 1'b1;
        #1;
        check("mg_gnt", gnt, 4'b0000);
        check("mg_line", bus_line, 1'b1);
        check("mg_tmo", tmo, 1'b0);
        step();
        rst    = 1'b0;
        m_last = 2'd3;
        check("mg_owner", owner, 2'd0);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] r2;
        int         f;
        rst          = 1'b1;
        req          = 4'b1111;
        done         = 1'b0;
        foreign_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_tmo", tmo, 1'b0);
        check("rst_line", bus_line, 1'b1);
        check("rst_owner", owner, 2'd0);
        rst    = 1'b0;
        m_last = 2'd3;

        // Round robin with done on the first grant cycle: 0,1,2,3,0.
        repeat (5) episode(4'b1111, 4'b1111, 0, 1, 1);
        // Timeout with a single requester, twice.
        repeat (2) episode(4'b0100, 4'b0100, 0, 0, 0);
        // done coinciding with the hold limit: no tmo.
        episode(4'b0100, 4'b0100, 0, 1, HOLD);
        // Foreign master holds the line for three edges.
        episode(4'b0010, 4'b0010, 3, 1, 2);
        // Request withdrawn at the ARB edge.
        episode(4'b1000, 4'b0000, 0, 0, 0);
        // req changes in ARB are honoured.
        episode(4'b0001, 4'b1010, 0, 2, 2);
        // Async reset mid-grant, then priority restarts at req[0].
        mid_grant_reset();
        episode(4'b1111, 4'b1111, 0, 1, 1);

        for (int n = 0; n < 60; n++) begin
            r  = 4'($urandom_range(1, 15));
            r2 = ($urandom_range(0, 7) == 0) ? 4'b0000 :
                 ($urandom_range(0, 1) == 1) ? r : 4'($urandom_range(1, 15));
            f  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            episode(r, r2, f, int'($urandom_range(0, 2)), int'($urandom_range(1, HOLD + 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
